lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//   Leaky integrate-and-fire neuron that produces the post-synaptic spike the
//   stdp learner consumes. It integrates the learned weight on each pre_spike,
//   leaks every enabled step and fires a one-cycle post_spike at threshold.
//   After each spike it holds a refractory period. Sits beside stdp in
//   tt_um_stdp; stdp.weight drives weight and post_spike feeds stdp.post_spike.
// PARAMETERS
//   WIDTH       8    membrane/weight width in bits
//   THRESHOLD   200  firing threshold; legal range 1 .. 2^WIDTH-1
//   LEAK_SHIFT  3    leak per step = membrane >> LEAK_SHIFT
//   REFRACT     4    enabled steps ignored after a spike; 0 = no refractory
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   ena          in   1      step enable; 0 = hold all state
//   clr          in   1      synchronous clear of neuron state and spike count
//   pre_spike    in   1      pre-synaptic spike, sampled while ena=1
//   weight       in   WIDTH  synaptic weight, unsigned, added on pre_spike
//   post_spike   out  1      one-cycle pulse when the neuron fires
//   membrane     out  WIDTH  current membrane potential, registered
//   refractory   out  1      1 while in the REFRACTORY state
//   spike_count  out  8      saturating count of post_spike pulses
// BEHAVIOUR
//   - Reset (rst_n=0, async): membrane=0, post_spike=0, refractory=0,
//     spike_count=0, state=INTEGRATE, refractory counter=0.
//   - All outputs are registered. post_spike is 0 on every cycle except the
//     one following a fire decision, including when ena=0.
//   - States: INTEGRATE, REFRACTORY. refractory output = (state==REFRACTORY).
//   - INTEGRATE with ena=1: compute on WIDTH+1 bits
//     v_next = membrane - (membrane>>LEAK_SHIFT) + (pre_spike ? weight : 0),
//     then saturate to 2^WIDTH-1.
//     - If v_next >= THRESHOLD, at the clock edge: membrane<=0, post_spike<=1,
//       spike_count += 1 (saturates at 255). If REFRACT>0 then cnt<=REFRACT and
//       state<=REFRACTORY; otherwise stay in INTEGRATE.
//     - Else membrane<=v_next.
//   - Leak floor: for membrane < 2^LEAK_SHIFT the leak term is 0, so the
//     membrane holds its value. No decay to zero is required.
//   - REFRACTORY with ena=1: membrane stays 0 and pre_spike/weight are ignored.
//     If cnt<=1: cnt<=0 and state<=INTEGRATE; else cnt<=cnt-1.
//     Exactly REFRACT enabled cycles are ignored. The next enabled cycle
//     integrates starting from v=0.
//   - ena=0: membrane, state, cnt and spike_count hold; post_spike<=0.
//   - clr=1 (regardless of ena): same values as reset, applied synchronously.
//     clr has priority over a same-cycle fire, so no post_spike is issued.
//   - rst_n asserted mid-REFRACTORY or mid-pulse: outputs clear immediately.
//     After release the neuron starts in INTEGRATE.
//   - Defaults are used for all values below unless stated otherwise.
// TESTING
//   1. Assert rst_n=0 with pre_spike=1, weight=255 -> all outputs 0.
//      Release rst_n with ena=0 -> outputs stay 0.
//   2. ena=1, one pre_spike with weight=50, then no spikes -> membrane
//      50, 44, 39, 35, 31; post_spike stays 0.
//   3. pre_spike on 2 consecutive cycles, weight=120 -> membrane 120; then
//      fire (120-15+120=225 >= 200) -> post_spike high for exactly 1 cycle,
//      membrane=0, refractory=1, spike_count=1.
//   4. Continue pre_spike with weight=255 -> the 4 enabled refractory cycles
//      ignore input (membrane=0). The 5th cycle gives 255 >= 200 -> fires again,
//      spike_count=2. With ena toggled 0/1 the refractory time counts enabled
//      cycles only.
//   5. Drive 300 fires -> spike_count saturates at 255.
//      Assert clr in the cycle a fire would occur -> no post_spike;
//      membrane=0, spike_count=0, refractory=0.
//   6. Assert rst_n asynchronously mid-REFRACTORY (cnt=2) -> outputs clear
//      before the next edge. After release, weight=210 with a pre_spike fires
//      on the first enabled cycle.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weight on pre_spike, leaks by
// membrane>>LEAK_SHIFT each enabled step, fires a registered one-cycle pulse at threshold.
module lif_neuron #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned THRESHOLD  = 200,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned REFRACT    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             pre_spike,
    input  logic [WIDTH-1:0] weight,
    output logic             post_spike,
    output logic [WIDTH-1:0] membrane,
    output logic             refractory,
    output logic [7:0]       spike_count
);

    localparam int unsigned CW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0] mem_n;
    logic            post_n;
    logic [7:0]      count_n;
    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]  sum;
    logic [WIDTH-1:0] v_sat;

    // One extra bit catches overflow of membrane+weight before saturating.
    assign leak  = membrane >> LEAK_SHIFT;
    assign sum   = {1'b0, membrane} - {1'b0, leak} + (pre_spike ? {1'b0, weight} : '0);
    assign v_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INTEGRATE;
            cnt         <= '0;
            membrane    <= '0;
            post_spike  <= 1'b0;
            spike_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            membrane    <= mem_n;
            post_spike  <= post_n;
            spike_count <= count_n;
        end
    end

    assign refractory = (state == REFRACTORY);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mem_n   = membrane;
        post_n  = 1'b0;
        count_n = spike_count;
        if (ena) begin
            case (state)
                INTEGRATE: begin
                    if (v_sat >= THR) begin
                        mem_n  = '0;
                        post_n = 1'b1;
                        if (spike_count != 8'hFF)
                            count_n = spike_count + 8'd1;
                        if (REFRACT > 0) begin
                            cnt_n   = CW'(REFRACT);
                            state_n = REFRACTORY;
                        end
                    end else begin
                        mem_n = v_sat;
                    end
                end
                REFRACTORY: begin
                    mem_n = '0;
                    if (cnt <= CW'(1)) begin
                        cnt_n   = '0;
                        state_n = INTEGRATE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: state_n = INTEGRATE;
            endcase
        end
        // Clear overrides everything, including a fire decided this cycle.
        if (clr) begin
            state_n = INTEGRATE;
            cnt_n   = '0;
            mem_n   = '0;
            post_n  = 1'b0;
            count_n = '0;
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed-vector bench for lif_neuron with hand-computed expected values.
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       pre_spike;
    logic [7:0] weight;
    logic       post_spike;
    logic [7:0] membrane;
    logic       refractory;
    logic [7:0] spike_count;

    int checks = 0;
    int failures = 0;

    lif_neuron #(
        .WIDTH(8),
        .THRESHOLD(200),
        .LEAK_SHIFT(3),
        .REFRACT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .clr(clr),
        .pre_spike(pre_spike),
        .weight(weight),
        .post_spike(post_spike),
        .membrane(membrane),
        .refractory(refractory),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] m, input logic p,
                             input logic r, input logic [7:0] c);
        check({tag, ".membrane"}, 32'(membrane), 32'(m));
        check({tag, ".post"}, 32'(post_spike), 32'(p));
        check({tag, ".refr"}, 32'(refractory), 32'(r));
        check({tag, ".count"}, 32'(spike_count), 32'(c));
    endtask

    logic [7:0] leak_seq [5] = '{8'd50, 8'd44, 8'd39, 8'd35, 8'd31};

    initial begin
        // 1. reset with aggressive inputs
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; pre_spike = 1'b1; weight = 8'd255;
        tick(); tick();
        check_all("reset", 8'd0, 1'b0, 1'b0, 8'd0);
        ena = 1'b0;
        #2 rst_n = 1'b1;
        tick(); tick();
        check_all("post_reset_ena0", 8'd0, 1'b0, 1'b0, 8'd0);

        // 2. single weight then leak
        ena = 1'b1; pre_spike = 1'b1; weight = 8'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            pre_spike = 1'b0;
            check($sformatf("leak%0d", i), 32'(membrane), 32'(leak_seq[i]));
            check($sformatf("leak_post%0d", i), 32'(post_spike), 32'd0);
        end

        // leak floor: 7 >> 3 == 0 so the value holds
        clr = 1'b1; tick(); clr = 1'b0;
        pre_spike = 1'b1; weight = 8'd7; tick();
        pre_spike = 1'b0; tick(); tick();
        check("leak_floor", 32'(membrane), 32'd7);

        // threshold boundary: 199 stays, 200 fires
        clr = 1'b1; tick(); clr = 1'b0;
        pre_spike = 1'b1; weight = 8'd199; tick();
        check_all("thr199", 8'd199, 1'b0, 1'b0, 8'd0);
        clr = 1'b1; pre_spike = 1'b0; tick(); clr = 1'b0;
        pre_spike = 1'b1; weight = 8'd200; tick();
        check_all("thr200", 8'd0, 1'b1, 1'b1, 8'd1);

        // 3. two consecutive weight-120 spikes
        clr = 1'b1; pre_spike = 1'b0; tick(); clr = 1'b0;
        check_all("clr", 8'd0, 1'b0, 1'b0, 8'd0);
        pre_spike = 1'b1; weight = 8'd120; tick();
        check_all("int120", 8'd120, 1'b0, 1'b0, 8'd0);
        tick();
        check_all("fire1", 8'd0, 1'b1, 1'b1, 8'd1);

        // 4. refractory ignores input for exactly 4 enabled cycles
        weight = 8'd255;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all($sformatf("refr%0d", i), 8'd0, 1'b0, (i < 3) ? 1'b1 : 1'b0, 8'd1);
        end
        tick();
        check_all("fire2", 8'd0, 1'b1, 1'b1, 8'd2);

        // refractory counts enabled cycles only
        for (int i = 0; i < 4; i++) begin
            ena = 1'b0; tick(); tick();
            check($sformatf("gap_refr%0d", i), 32'(refractory), 32'd1);
            check($sformatf("gap_post%0d", i), 32'(post_spike), 32'd0);
            ena = 1'b1; tick();
            check($sformatf("en_refr%0d", i), 32'(refractory), (i < 3) ? 32'd1 : 32'd0);
        end
        tick();
        check_all("fire3", 8'd0, 1'b1, 1'b1, 8'd3);

        // 5. 300 more fires; count saturates
        for (int i = 0; i < 300 * 5; i++) tick();
        check("sat_count", 32'(spike_count), 32'd255);
        check("sat_post", 32'(post_spike), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("pre_clr_refr", 32'(refractory), 32'd0);
        clr = 1'b1; tick(); clr = 1'b0;
        check_all("clr_vs_fire", 8'd0, 1'b0, 1'b0, 8'd0);

        // 6. async reset mid-refractory (cnt=2)
        tick();
        check_all("fire_r6", 8'd0, 1'b1, 1'b1, 8'd1);
        tick(); tick();
        check("mid_refr", 32'(refractory), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'd0, 1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        weight = 8'd210; pre_spike = 1'b1; ena = 1'b1;
        tick();
        check_all("after_rst_fire", 8'd0, 1'b1, 1'b1, 8'd1);

        // async reset during the post_spike pulse
        #2 rst_n = 1'b0;
        #1;
        check_all("rst_mid_pulse", 8'd0, 1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
